// File: rtl/sysbus_arb_pkg.sv
// Shared types for the Sysbus port arbiter: FSM state encoding and owner IDs.
// The owner bit remembers which client a DRAIN phase belongs to.
package sysbus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2,
      DRAIN   = 2'd3
   } arb_state_e;

   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

   // A client holds the bus in its own GRANT state, or in DRAIN when it was the last owner
   function automatic logic grant_for(input arb_state_e st, input logic owner, input logic who);
      logic granted;
      granted = 1'b0;
      case (st)
         GRANT_I: granted = (who == OWNER_I);
         GRANT_D: granted = (who == OWNER_D);
         DRAIN:   granted = (owner == who);
         default: granted = 1'b0;
      endcase
      return granted;
   endfunction

endpackage

// File: rtl/sysbus_port_arbiter.sv
// Two-client (fetch/memory) arbiter and request mux in front of the single Sysbus port.
// Grants are held until the owner releases and any response burst has drained.
module sysbus_port_arbiter
   import sysbus_arb_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13
) (
   input  logic                      clk,
   input  logic                      reset,

   input  logic                      icache_busreq,
   input  logic                      icache_busidle,
   output logic                      icache_busgrant,
   input  logic                      icache_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] icache_req,
   input  logic [BUS_TAG_WIDTH-1:0]  icache_reqtag,
   input  logic                      icache_respack,
   output logic                      icache_reqack,
   output logic                      icache_respcyc,

   input  logic                      dcache_busreq,
   input  logic                      dcache_busidle,
   output logic                      dcache_busgrant,
   input  logic                      dcache_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] dcache_req,
   input  logic [BUS_TAG_WIDTH-1:0]  dcache_reqtag,
   input  logic                      dcache_respack,
   output logic                      dcache_reqack,
   output logic                      dcache_respcyc,

   output logic                      bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   output logic                      bus_respack,
   input  logic                      bus_reqack,
   input  logic                      bus_respcyc,
   output logic                      bus_violation
);

   arb_state_e state, state_next;
   logic       owner, owner_next;
   logic       icache_release, dcache_release;

   assign icache_release = icache_busidle | ~icache_busreq;
   assign dcache_release = dcache_busidle | ~dcache_busreq;

   // Next-state: fixed dcache priority from IDLE, no preemption, always pass through IDLE
   always_comb begin
      state_next = state;
      owner_next = owner;
      case (state)
         IDLE: begin
            if (dcache_busreq) begin
               state_next = GRANT_D;
               owner_next = OWNER_D;
            end else if (icache_busreq) begin
               state_next = GRANT_I;
               owner_next = OWNER_I;
            end
         end
         GRANT_I: begin
            if (icache_release) state_next = bus_respcyc ? DRAIN : IDLE;
         end
         GRANT_D: begin
            if (dcache_release) state_next = bus_respcyc ? DRAIN : IDLE;
         end
         DRAIN: begin
            if (!bus_respcyc) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Grants are flops decoded from the next state so they change exactly with the state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         owner           <= OWNER_I;
         icache_busgrant <= 1'b0;
         dcache_busgrant <= 1'b0;
      end else begin
         state           <= state_next;
         owner           <= owner_next;
         icache_busgrant <= grant_for(state_next, owner_next, OWNER_I);
         dcache_busgrant <= grant_for(state_next, owner_next, OWNER_D);
      end
   end

   // Sticky flag for a client driving a request while it does not own the bus
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus_violation <= 1'b0;
      end else if ((icache_reqcyc && !icache_busgrant) || (dcache_reqcyc && !dcache_busgrant)) begin
         bus_violation <= 1'b1;
      end
   end

   // Request-side mux: only the granted client reaches the bus, otherwise drive zeros
   always_comb begin
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      bus_respack = 1'b0;
      if (icache_busgrant) begin
         bus_reqcyc  = icache_reqcyc;
         bus_req     = icache_req;
         bus_reqtag  = icache_reqtag;
         bus_respack = icache_respack;
      end else if (dcache_busgrant) begin
         bus_reqcyc  = dcache_reqcyc;
         bus_req     = dcache_req;
         bus_reqtag  = dcache_reqtag;
         bus_respack = dcache_respack;
      end
   end

   assign icache_reqack  = bus_reqack  & icache_busgrant;
   assign icache_respcyc = bus_respcyc & icache_busgrant;
   assign dcache_reqack  = bus_reqack  & dcache_busgrant;
   assign dcache_respcyc = bus_respcyc & dcache_busgrant;

endmodule

// File: tb/tb_sysbus_port_arbiter.sv
// Self-checking bench for sysbus_port_arbiter: directed scenarios plus random traffic
// compared against an owner-level reference model.
module tb_sysbus_port_arbiter;

   localparam int DW = 64;
   localparam int TW = 13;

   logic          clk = 1'b0;
   logic          reset;
   logic          icache_busreq, icache_busidle, icache_busgrant, icache_reqcyc, icache_respack;
   logic [DW-1:0] icache_req;
   logic [TW-1:0] icache_reqtag;
   logic          icache_reqack, icache_respcyc;
   logic          dcache_busreq, dcache_busidle, dcache_busgrant, dcache_reqcyc, dcache_respack;
   logic [DW-1:0] dcache_req;
   logic [TW-1:0] dcache_reqtag;
   logic          dcache_reqack, dcache_respcyc;
   logic          bus_reqcyc, bus_respack, bus_reqack, bus_respcyc, bus_violation;
   logic [DW-1:0] bus_req;
   logic [TW-1:0] bus_reqtag;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model: who holds the bus (0 none, 1 icache, 2 dcache), whether a burst drains
   int mOwner;
   bit mDrain;
   bit mViol;

   always #5 clk = ~clk;

   sysbus_port_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) dut (
      .clk(clk), .reset(reset),
      .icache_busreq(icache_busreq), .icache_busidle(icache_busidle), .icache_busgrant(icache_busgrant),
      .icache_reqcyc(icache_reqcyc), .icache_req(icache_req), .icache_reqtag(icache_reqtag),
      .icache_respack(icache_respack), .icache_reqack(icache_reqack), .icache_respcyc(icache_respcyc),
      .dcache_busreq(dcache_busreq), .dcache_busidle(dcache_busidle), .dcache_busgrant(dcache_busgrant),
      .dcache_reqcyc(dcache_reqcyc), .dcache_req(dcache_req), .dcache_reqtag(dcache_reqtag),
      .dcache_respack(dcache_respack), .dcache_reqack(dcache_reqack), .dcache_respcyc(dcache_respcyc),
      .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_respack(bus_respack),
      .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_violation(bus_violation)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic clearInputs();
      icache_busreq = 0; icache_busidle = 0; icache_reqcyc = 0; icache_respack = 0;
      icache_req = '0; icache_reqtag = '0;
      dcache_busreq = 0; dcache_busidle = 0; dcache_reqcyc = 0; dcache_respack = 0;
      dcache_req = '0; dcache_reqtag = '0;
      bus_reqack = 0; bus_respcyc = 0;
   endtask

   // Compare every DUT output against what the model says should be visible now
   task automatic checkAll();
      bit ig, dg;
      logic [DW-1:0] eReq;
      logic [TW-1:0] eTag;
      logic eCyc, eAck;
      ig = (mOwner == 1);
      dg = (mOwner == 2);
      eCyc = ig ? icache_reqcyc  : dg ? dcache_reqcyc  : 1'b0;
      eReq = ig ? icache_req     : dg ? dcache_req     : '0;
      eTag = ig ? icache_reqtag  : dg ? dcache_reqtag  : '0;
      eAck = ig ? icache_respack : dg ? dcache_respack : 1'b0;
      checkOutput("icache_busgrant", icache_busgrant, ig);
      checkOutput("dcache_busgrant", dcache_busgrant, dg);
      checkOutput("bus_reqcyc",      bus_reqcyc, eCyc);
      checkOutput("bus_req",         bus_req, eReq);
      checkOutput("bus_reqtag",      bus_reqtag, eTag);
      checkOutput("bus_respack",     bus_respack, eAck);
      checkOutput("icache_reqack",   icache_reqack,  bus_reqack  & ig);
      checkOutput("dcache_reqack",   dcache_reqack,  bus_reqack  & dg);
      checkOutput("icache_respcyc",  icache_respcyc, bus_respcyc & ig);
      checkOutput("dcache_respcyc",  dcache_respcyc, bus_respcyc & dg);
      checkOutput("bus_violation",   bus_violation, mViol);
   endtask

   // Advance the model by one clock using the inputs the DUT samples at the coming edge
   task automatic modelStep();
      bit released;
      if (reset) begin
         mOwner = 0; mDrain = 0; mViol = 0;
         return;
      end
      if ((icache_reqcyc && mOwner != 1) || (dcache_reqcyc && mOwner != 2)) mViol = 1;
      if (mOwner == 0) begin
         if (dcache_busreq)      mOwner = 2;
         else if (icache_busreq) mOwner = 1;
      end else if (mDrain) begin
         if (!bus_respcyc) begin mOwner = 0; mDrain = 0; end
      end else begin
         released = (mOwner == 1) ? (icache_busidle || !icache_busreq)
                                  : (dcache_busidle || !dcache_busreq);
         if (released) begin
            if (bus_respcyc) mDrain = 1;
            else             mOwner = 0;
         end
      end
   endtask

   // Called at a negedge once inputs are set: check, advance the model, move to the next negedge
   task automatic applyStimulus();
      #1;
      if (reset) begin mOwner = 0; mDrain = 0; mViol = 0; end
      checkAll();
      modelStep();
      @(negedge clk);
   endtask

   initial begin
      reset = 1;
      clearInputs();
      mOwner = 0; mDrain = 0; mViol = 0;
      @(negedge clk);
      applyStimulus();
      reset = 0;
      applyStimulus();

      // Reset in the middle of a dcache transaction
      dcache_busreq = 1; dcache_reqcyc = 1; dcache_req = 64'h1111_2222_3333_4444;
      applyStimulus();
      checkOutput("t1_dgrant", dcache_busgrant, 1);
      applyStimulus();
      checkOutput("t1_busreqcyc", bus_reqcyc, 1);
      reset = 1;
      #1;
      checkOutput("t1_async_grant", dcache_busgrant, 0);
      checkOutput("t1_async_reqcyc", bus_reqcyc, 0);
      applyStimulus();
      clearInputs();
      reset = 0;
      icache_busreq = 1;
      applyStimulus();
      checkOutput("t1_igrant_after_reset", icache_busgrant, 1);

      // Simultaneous requests: dcache wins, then icache after one idle cycle
      icache_busreq = 0;
      applyStimulus();
      applyStimulus();
      icache_busreq = 1; dcache_busreq = 1;
      applyStimulus();
      checkOutput("t2_dgrant", dcache_busgrant, 1);
      checkOutput("t2_ino_grant", icache_busgrant, 0);
      dcache_busidle = 1; dcache_busreq = 0;
      applyStimulus();
      checkOutput("t2_gap_d", dcache_busgrant, 0);
      checkOutput("t2_gap_i", icache_busgrant, 0);
      dcache_busidle = 0;
      applyStimulus();
      checkOutput("t2_igrant", icache_busgrant, 1);

      // Request payload passes through, acks gated to owner
      icache_req = 64'hDEAD_BEEF_0000_1234; icache_reqtag = 13'h0400; icache_reqcyc = 1; bus_reqack = 1;
      applyStimulus();
      checkOutput("t3_bus_req", bus_req, 64'hDEAD_BEEF_0000_1234);
      checkOutput("t3_bus_reqtag", bus_reqtag, 13'h0400);
      checkOutput("t3_icache_reqack", icache_reqack, 1);
      checkOutput("t3_dcache_reqack", dcache_reqack, 0);

      // Release during an 8-beat response burst
      icache_reqcyc = 0; bus_reqack = 0; bus_respcyc = 1; icache_busidle = 1;
      applyStimulus();
      icache_busidle = 0; icache_busreq = 0;
      for (int b = 0; b < 7; b++) begin
         bus_respcyc = 1;
         #1;
         checkOutput("t4_icache_respcyc", icache_respcyc, 1);
         checkOutput("t4_dcache_respcyc", dcache_respcyc, 0);
         applyStimulus();
      end
      bus_respcyc = 0;
      #1;
      checkOutput("t4_grant_held", icache_busgrant, 1);
      applyStimulus();
      checkOutput("t4_grant_dropped", icache_busgrant, 0);

      // Non-owner drives reqcyc: sticky violation, mux still follows owner
      icache_busreq = 1;
      applyStimulus();
      icache_req = 64'h0123_4567_89AB_CDEF; dcache_reqcyc = 1; dcache_req = 64'hFFFF_0000_FFFF_0000;
      applyStimulus();
      checkOutput("t5_violation", bus_violation, 1);
      checkOutput("t5_bus_req", bus_req, 64'h0123_4567_89AB_CDEF);
      dcache_reqcyc = 0; icache_busreq = 0;
      repeat (4) applyStimulus();
      checkOutput("t5_violation_sticky", bus_violation, 1);
      reset = 1;
      applyStimulus();
      clearInputs();
      reset = 0;
      applyStimulus();
      checkOutput("t5_violation_cleared", bus_violation, 0);

      // Back-to-back dcache transactions starve the icache
      dcache_busreq = 1; icache_busreq = 1;
      for (int i = 0; i < 18; i++) begin
         dcache_busidle = (i % 3 == 2);
         applyStimulus();
         checkOutput("t6_icache_starved", icache_busgrant, 0);
      end
      clearInputs();
      applyStimulus();

      // Random traffic against the model
      for (int i = 0; i < 2000; i++) begin
         reset = ($urandom_range(0, 249) == 0);
         if ($urandom_range(0, 5) == 0) icache_busreq = ~icache_busreq;
         if ($urandom_range(0, 5) == 0) dcache_busreq = ~dcache_busreq;
         icache_busidle = ($urandom_range(0, 7) == 0);
         dcache_busidle = ($urandom_range(0, 7) == 0);
         icache_reqcyc  = (mOwner == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 59) == 0);
         dcache_reqcyc  = (mOwner == 2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 59) == 0);
         icache_req     = {$urandom, $urandom};
         dcache_req     = {$urandom, $urandom};
         icache_reqtag  = TW'($urandom);
         dcache_reqtag  = TW'($urandom);
         icache_respack = 1'($urandom_range(0, 1));
         dcache_respack = 1'($urandom_range(0, 1));
         bus_reqack     = 1'($urandom_range(0, 1));
         bus_respcyc    = ($urandom_range(0, 2) == 0);
         applyStimulus();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/sysbus_port_arbiter.md
Name: sysbus_port_arbiter

Overview:
Grant/mux stage directly downstream of the fetch (icache) and memory (dcache) stages and upstream of the single Sysbus port of the core. It arbitrates the two bus requesters with a registered state machine. It muxes the granted client's request-side signals onto the bus and gates the bus acknowledges back to the granted client only. It holds each grant until the client is idle and any response burst has drained.

Parameters:
BUS_DATA_WIDTH, 64, width of bus_req / request data
BUS_TAG_WIDTH, 13, width of bus_reqtag

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
icache_busreq  in  1  fetch requests bus ownership (level)
icache_busidle  in  1  fetch transaction complete; release request
icache_busgrant  out  1  fetch owns bus
icache_reqcyc  in  1  fetch request-valid
icache_req  in  BUS_DATA_WIDTH  fetch request payload
icache_reqtag  in  BUS_TAG_WIDTH  fetch request tag
icache_respack  in  1  fetch response ack
icache_reqack  out  1  gated bus_reqack
icache_respcyc  out  1  gated bus_respcyc
dcache_busreq, dcache_busidle, dcache_busgrant, dcache_reqcyc, dcache_req, dcache_reqtag, dcache_respack, dcache_reqack, dcache_respcyc  same as icache_* for the memory stage
bus_reqcyc  out  1  to Sysbus
bus_req  out  BUS_DATA_WIDTH  to Sysbus
bus_reqtag  out  BUS_TAG_WIDTH  to Sysbus
bus_respack  out  1  to Sysbus
bus_reqack  in  1  from Sysbus
bus_respcyc  in  1  from Sysbus
bus_violation  out  1  sticky: non-granted client drove reqcyc
(bus_resp and bus_resptag are wired directly to both clients and do not pass through this block.)

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous and active-high. On reset: state=IDLE, both busgrant=0, all bus_* outputs=0, both reqack/respcyc=0, bus_violation=0. Reset mid-transaction abandons the transaction immediately.
- States: IDLE, GRANT_I, GRANT_D, DRAIN.
- IDLE:
  - dcache_busreq=1 -> GRANT_D. The dcache has fixed priority, so the memory stage is never blocked behind a speculative fetch.
  - else icache_busreq=1 -> GRANT_I.
  - else stay in IDLE.
- GRANT_x:
  - On x_busidle=1 or x_busreq=0: go to IDLE if bus_respcyc=0, else DRAIN.
  - A request from the other client is ignored; no preemption.
- DRAIN: remains until bus_respcyc=0, then goes to IDLE. Grant stays with the previous owner; tracked by a 1-bit owner register.
- Grant timing: busgrant is a registered decode of state. It asserts 1 cycle after busreq is sampled in IDLE and deasserts in the cycle state leaves GRANT/DRAIN. There is a minimum of one IDLE cycle between consecutive grants. Both grants are never 1 simultaneously.
- Request mux (combinational on registered owner/state): bus_reqcyc/bus_req/bus_reqtag/bus_respack = the owner's signals while granted, else all 0.
- Ack gating:
  - x_reqack = bus_reqack & x_busgrant.
  - x_respcyc = bus_respcyc & x_busgrant.
  - Non-owner always sees 0.
- Violation: bus_violation sets when a client's reqcyc=1 while its busgrant=0. It is sticky until reset.
- Simultaneous events:
  - Release and new request in the same cycle: release to IDLE, new grant next cycle.
  - busidle and busreq both 1 in GRANT: treated as release.

Decomposition:
- Shared package sysbus_arb_pkg: state enum (IDLE, GRANT_I, GRANT_D, DRAIN), owner encoding constants (OWNER_I=0, OWNER_D=1).
- Single module, no sub-module; the mux is inline.

Test Plan:
1. Reset asserted mid-GRANT_D with bus_reqcyc=1 -> next edge all outputs 0, state IDLE; released reset with icache_busreq=1 -> icache_busgrant=1 one cycle later.
2. icache_busreq and dcache_busreq rise in the same cycle -> dcache_busgrant=1 next cycle, icache_busgrant=0; dcache_busidle pulse -> IDLE one cycle, then icache_busgrant=1.
3. GRANT_I, icache_req=0xDEAD_BEEF_0000_1234, reqtag=0x0400, reqcyc=1 -> bus_req/bus_reqtag match exactly; bus_reqack=1 -> icache_reqack=1, dcache_reqack=0.
4. Release while bus_respcyc=1 for 8 beats -> state DRAIN; icache_respcyc follows all 8 beats; grant drops the cycle after bus_respcyc=0.
5. dcache_reqcyc=1 while GRANT_I -> bus_violation=1 and held through later idle cycles until reset; bus outputs still follow icache.
6. Back-to-back dcache requests (busreq held, busidle pulsed every 3 cycles) with icache_busreq held -> strict dcache priority; the one-cycle IDLE gap appears between every grant.
